// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared defaults and helpers for the hazard scoreboard.
//   REG_AW_DEF   : register-address width (NUM_REGS = 2**REG_AW)
//   WB_LAT_DEF   : cycles a producer blocks dependents, forwarding off
//   LOAD_USE_DEF : cycles a load blocks dependents, forwarding on
//   cnt_width()  : bits needed to hold max(WB_LAT, LOAD_USE)
package hazard_pkg;

    localparam int REG_AW_DEF   = 5;
    localparam int WB_LAT_DEF   = 2;
    localparam int LOAD_USE_DEF = 1;

    function automatic int cnt_width(input int wb_lat, input int load_use);
        int m;
        m = (wb_lat > load_use) ? wb_lat : load_use;
        // never let a zero-latency configuration produce a zero-width counter
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/hazard_cnt_cell.sv
// hazard_cnt_cell
//   One per-register busy counter: decrement while running, hold while
//   frozen, and on a new load keep the larger of the loaded value and the
//   decremented old value so an older, longer-latency writer is not hidden.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     freeze    : hold the counter
//     load_en   : a new producer of this register issues this cycle
//     load_val  : block length requested by the new producer
//     busy      : counter is nonzero
module hazard_cnt_cell #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          load_en,
    input  logic [CW-1:0] load_val,
    output logic          busy
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] dec;

    always_comb begin
        dec = (cnt != '0) ? cnt - CW'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!freeze) begin
            if (load_en && (load_val > dec))
                cnt <= load_val;
            else
                cnt <= dec;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Register-hazard scoreboard for the ID stage. Each architectural register
//   has a countdown of cycles during which a dependent must stall; register 0
//   is hardwired free.
//   Optional feature: define HAZARD_PERF_CNT_EN to add the stall_cycles
//   performance counter output.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     id_valid, freeze  : ID instruction present / pipeline frozen
//     src1, src2        : source registers (src2 only used when two_regs)
//     dest, wb_en       : destination register and write enable
//     is_load, en_fwd   : producer is a load / forwarding mode at issue
//     hazard_detected   : stall ID this cycle
//     issue_accept      : ID instruction leaves ID this cycle
//     busy_mask         : per-register counter-nonzero flags
//     stall_cycles      : saturating count of unfrozen stall cycles (optional)
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int WB_LAT   = WB_LAT_DEF,
    parameter int LOAD_USE = LOAD_USE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic                   freeze,
    input  logic [REG_AW-1:0]      src1,
    input  logic [REG_AW-1:0]      src2,
    input  logic                   two_regs,
    input  logic [REG_AW-1:0]      dest,
    input  logic                   wb_en,
    input  logic                   is_load,
    input  logic                   en_fwd,
    output logic                   hazard_detected,
    output logic                   issue_accept,
    output logic [(2**REG_AW)-1:0] busy_mask
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]            stall_cycles
`endif
);

    localparam int NUM_REGS = 2**REG_AW;
    localparam int CW       = cnt_width(WB_LAT, LOAD_USE);
    localparam logic [CW-1:0] WB_VAL   = CW'(WB_LAT);
    localparam logic [CW-1:0] LOAD_VAL = CW'(LOAD_USE);

    logic [NUM_REGS-1:0] busy;
    logic [CW-1:0]       load_val;
    logic                src1_hit;
    logic                src2_hit;

    // en_fwd is only looked at here, so a mode change never touches
    // counters that are already running.
    always_comb begin
        if (en_fwd)
            load_val = is_load ? LOAD_VAL : '0;
        else
            load_val = WB_VAL;
    end

    assign busy[0] = 1'b0;

    genvar r;
    generate
        for (r = 1; r < NUM_REGS; r++) begin : g_cell
            hazard_cnt_cell #(.CW(CW)) u_cell (
                .clk      (clk),
                .rst      (rst),
                .freeze   (freeze),
                .load_en  (issue_accept && wb_en && (dest == REG_AW'(r))),
                .load_val (load_val),
                .busy     (busy[r])
            );
        end
    endgenerate

    assign src1_hit        = (src1 != '0) && busy[src1];
    assign src2_hit        = two_regs && (src2 != '0) && busy[src2];
    assign hazard_detected = id_valid && (src1_hit || src2_hit);
    assign issue_accept    = id_valid && !hazard_detected && !freeze;
    assign busy_mask       = busy;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (hazard_detected && !freeze && (stall_cycles != 16'hFFFF))
            stall_cycles <= stall_cycles + 16'd1;
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Directed stimulus pushes the hand-computed expected outputs of every
//   driven cycle into a queue; a monitor on the falling edge pops and
//   compares. With HAZARD_PERF_CNT_EN defined a second instance with a long
//   writeback latency is driven into stall_cycles saturation.
module tb_hazard_scoreboard;

    typedef struct {
        logic        hz;
        logic        acc;
        logic [31:0] mask;
        logic [15:0] stall;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, freeze, two_regs, wb_en, is_load, en_fwd;
    logic [4:0]  src1, src2, dest;
    logic        hazard_detected, issue_accept;
    logic [31:0] busy_mask;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] stall_model = 16'd0;

    always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles;
    logic        s_valid;
    logic        s_hz, s_acc;
    logic [31:0] s_mask;
    logic [15:0] s_stall;
`endif

    hazard_scoreboard u_dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .freeze          (freeze),
        .src1            (src1),
        .src2            (src2),
        .two_regs        (two_regs),
        .dest            (dest),
        .wb_en           (wb_en),
        .is_load         (is_load),
        .en_fwd          (en_fwd),
        .hazard_detected (hazard_detected),
        .issue_accept    (issue_accept),
        .busy_mask       (busy_mask)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles    (stall_cycles)
`endif
    );

`ifdef HAZARD_PERF_CNT_EN
    // Self-sustaining loop: producer/consumer of r3, 15 stalls per issue.
    hazard_scoreboard #(.WB_LAT(15)) u_sat (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (s_valid),
        .freeze          (1'b0),
        .src1            (5'd3),
        .src2            (5'd0),
        .two_regs        (1'b0),
        .dest            (5'd3),
        .wb_en           (1'b1),
        .is_load         (1'b0),
        .en_fwd          (1'b0),
        .hazard_detected (s_hz),
        .issue_accept    (s_acc),
        .busy_mask       (s_mask),
        .stall_cycles    (s_stall)
    );
`endif

    function automatic logic [31:0] m(input int n);
        logic [31:0] one;
        one = 32'd1;
        return one << n;
    endfunction

    task automatic step(input logic r, input logic v, input logic fz,
                        input logic [4:0] s1, input logic [4:0] s2, input logic two,
                        input logic [4:0] d, input logic wb, input logic ld, input logic fwd,
                        input logic eh, input logic ea, input logic [31:0] em);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_valid = v; freeze = fz; src1 = s1; src2 = s2; two_regs = two;
        dest = d; wb_en = wb; is_load = ld; en_fwd = fwd;
        e.hz = eh; e.acc = ea; e.mask = em; e.stall = stall_model;
        exp_q.push_back(e);
        if (r)
            stall_model = 16'd0;
        else if (eh && !fz && stall_model != 16'hFFFF)
            stall_model = stall_model + 16'd1;
    endtask

    // Monitor: compare whatever the current cycle is expected to show.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests++;
            if (hazard_detected !== e.hz) begin
                fails++;
                $display("FAIL hazard_detected @%0t: got %b want %b", $time, hazard_detected, e.hz);
            end
            tests++;
            if (issue_accept !== e.acc) begin
                fails++;
                $display("FAIL issue_accept @%0t: got %b want %b", $time, issue_accept, e.acc);
            end
            tests++;
            if (busy_mask !== e.mask) begin
                fails++;
                $display("FAIL busy_mask @%0t: got %h want %h", $time, busy_mask, e.mask);
            end
`ifdef HAZARD_PERF_CNT_EN
            tests++;
            if (stall_cycles !== e.stall) begin
                fails++;
                $display("FAIL stall_cycles @%0t: got %0d want %0d", $time, stall_cycles, e.stall);
            end
`endif
        end
    end

    initial begin
        int budget;
        rst = 1'b1; id_valid = 1'b0; freeze = 1'b0; src1 = '0; src2 = '0;
        two_regs = 1'b0; dest = '0; wb_en = 1'b0; is_load = 1'b0; en_fwd = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
        s_valid = 1'b0;
`endif
        repeat (2) @(posedge clk);

        //    r  v  fz s1 s2 two d  wb ld fwd  hz acc mask
        // reset state
        step(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 32'd0);
        // no forwarding: ADD r3 then consumer of r3 stalls 2 cycles
        step(0, 1, 0, 1, 2, 1,  3, 1, 0, 0,   0, 1, 32'd0);
        step(0, 1, 0, 3, 0, 0,  0, 0, 0, 0,   1, 0, m(3));
        step(0, 1, 0, 3, 0, 0,  0, 0, 0, 0,   1, 0, m(3));
        step(0, 1, 0, 3, 0, 0,  0, 0, 0, 0,   0, 1, 32'd0);
        // forwarding: load r5, src2 consumer with two_regs stalls 1
        step(0, 1, 0, 0, 0, 0,  5, 1, 1, 1,   0, 1, 32'd0);
        step(0, 1, 0, 0, 5, 1,  0, 0, 0, 1,   1, 0, m(5));
        step(0, 1, 0, 0, 5, 1,  0, 0, 0, 1,   0, 1, 32'd0);
        // same without two_regs: src2 ignored
        step(0, 1, 0, 0, 0, 0,  5, 1, 1, 1,   0, 1, 32'd0);
        step(0, 1, 0, 0, 5, 0,  0, 0, 0, 1,   0, 1, m(5));
        // forwarding non-load r7: no stall
        step(0, 1, 0, 0, 0, 0,  7, 1, 0, 1,   0, 1, 32'd0);
        step(0, 1, 0, 7, 0, 0,  0, 0, 0, 1,   0, 1, 32'd0);
        // dest=0 producer, then r0 consumer on both sources
        step(0, 1, 0, 0, 0, 0,  0, 1, 0, 0,   0, 1, 32'd0);
        step(0, 1, 0, 0, 0, 1,  0, 0, 0, 0,   0, 1, 32'd0);
        // max-merge: WB_LAT producer r6, then fwd non-load r6 must not shorten it
        step(0, 1, 0, 0, 0, 0,  6, 1, 0, 0,   0, 1, 32'd0);
        step(0, 1, 0, 0, 0, 0,  6, 1, 0, 1,   0, 1, m(6));
        step(0, 1, 0, 6, 0, 0,  0, 0, 0, 1,   1, 0, m(6));
        step(0, 1, 0, 6, 0, 0,  0, 0, 0, 1,   0, 1, 32'd0);
        // frozen independent producer: neither issues nor loads
        step(0, 1, 1, 1, 0, 0,  8, 1, 0, 0,   0, 0, 32'd0);
        // freeze 3 cycles with cnt[4]=2, stall length after release still 2
        step(0, 1, 0, 0, 0, 0,  4, 1, 0, 0,   0, 1, 32'd0);
        step(0, 1, 1, 4, 0, 0,  0, 0, 0, 0,   1, 0, m(4));
        step(0, 1, 1, 4, 0, 0,  0, 0, 0, 0,   1, 0, m(4));
        step(0, 1, 1, 4, 0, 0,  0, 0, 0, 0,   1, 0, m(4));
        step(0, 1, 0, 4, 0, 0,  0, 0, 0, 0,   1, 0, m(4));
        step(0, 1, 0, 4, 0, 0,  0, 0, 0, 0,   1, 0, m(4));
        step(0, 1, 0, 4, 0, 0,  0, 0, 0, 0,   0, 1, 32'd0);
        // reset while cnt[9]=2 clears everything
        step(0, 1, 0, 0, 0, 0,  9, 1, 0, 0,   0, 1, 32'd0);
        step(1, 1, 0, 9, 0, 0,  0, 0, 0, 0,   1, 0, m(9));
        step(0, 1, 0, 9, 0, 0,  0, 0, 0, 0,   0, 1, 32'd0);
        // reset wins over an accepted issue in the same cycle
        step(1, 1, 0, 0, 0, 0, 10, 1, 0, 0,   0, 1, 32'd0);
        step(0, 1, 0, 10, 0, 0, 0, 0, 0, 0,   0, 1, 32'd0);
        step(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 32'd0);

        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end

`ifdef HAZARD_PERF_CNT_EN
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        repeat (75000) @(posedge clk);
        @(negedge clk);
        tests++;
        if (s_stall !== 16'hFFFF) begin
            fails++;
            $display("FAIL stall_saturate: got %0d want 65535", s_stall);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
